mips_mem: RTL and testbench

//  Memory-side counterpart of the mips core: owns instruction memory and data memory.

---
 rtl/mips_mem_pkg.sv | 14 +
 rtl/mips_mem_if.sv | 29 ++
 rtl/mips_mem_array.sv | 22 ++
 rtl/mips_mem.sv | 122 ++++++++++++
 tb/tb_mips_mem.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_mem_pkg.sv
// Shared constants and FSM state type for the mips memory block.
package mips_mem_pkg;

    localparam int unsigned IW_DEF = 9;
    localparam int unsigned AW_DEF = 8;
    localparam int unsigned DW_DEF = 8;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_LOAD  = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

endpackage

// File: rtl/mips_mem_if.sv
// Loader stream plus core fetch/data port; master is the core/loader side, slave the memory.
interface mips_mem_if #(
    parameter int unsigned IW = 9,
    parameter int unsigned AW = 8,
    parameter int unsigned DW = 8
);
    logic          load_valid;
    logic          load_ready;
    logic [IW-1:0] load_data;
    logic          load_last;
    logic          core_rst;
    logic [AW:0]   prog_len;
    logic [AW-1:0] pc;
    logic [IW-1:0] inst;
    logic          MemWrite;
    logic [AW-1:0] ALUOut;
    logic [DW-1:0] rd2_Data;
    logic [DW-1:0] ReadData;

    modport master (
        output load_valid, load_data, load_last, pc, MemWrite, ALUOut, rd2_Data,
        input  load_ready, core_rst, prog_len, inst, ReadData
    );

    modport slave (
        input  load_valid, load_data, load_last, pc, MemWrite, ALUOut, rd2_Data,
        output load_ready, core_rst, prog_len, inst, ReadData
    );
endinterface

// File: rtl/mips_mem_array.sv
// Word-addressed RAM: one synchronous write port, one combinational read port.
module mips_mem_array #(
    parameter int unsigned W  = 8,
    parameter int unsigned AW = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);
    logic [W-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/mips_mem.sv
// Instruction/data memories for the mips core with a clear -> load -> run boot sequencer.
module mips_mem
    import mips_mem_pkg::*;
#(
    parameter int unsigned IW             = IW_DEF,
    parameter int unsigned AW             = AW_DEF,
    parameter int unsigned DW             = DW_DEF,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic      clk,
    input  logic      rst,
    mips_mem_if.slave bus
);
    localparam logic [AW-1:0] MAX_ADDR = '1;
    localparam logic [AW:0]   LEN_MAX  = {1'b1, {AW{1'b0}}};

    state_t        state;
    logic [AW-1:0] clr_cnt;
    logic [AW-1:0] ld_addr;
    logic [AW:0]   prog_len;
    logic          load_ready;
    logic          xfer;

    logic          imem_we;
    logic [AW-1:0] imem_waddr;
    logic [IW-1:0] imem_wdata;
    logic          dmem_we;
    logic [AW-1:0] dmem_waddr;
    logic [DW-1:0] dmem_wdata;

    assign xfer = (state == ST_LOAD) && bus.load_valid && load_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= CLEAR_ON_RESET ? ST_CLEAR : ST_LOAD;
            clr_cnt    <= '0;
            ld_addr    <= '0;
            prog_len   <= '0;
            load_ready <= 1'b0;
        end else begin
            unique case (state)
                ST_CLEAR: begin
                    clr_cnt <= clr_cnt + AW'(1);
                    if (clr_cnt == MAX_ADDR) begin
                        state      <= ST_LOAD;
                        load_ready <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    load_ready <= 1'b1;
                    if (xfer) begin
                        ld_addr <= ld_addr + AW'(1);
                        if (prog_len != LEN_MAX) begin
                            prog_len <= prog_len + (AW+1)'(1);
                        end
                        // Filling the last address ends loading even without load_last.
                        if (bus.load_last || ld_addr == MAX_ADDR) begin
                            state      <= ST_RUN;
                            load_ready <= 1'b0;
                        end
                    end
                end
                ST_RUN: begin
                    load_ready <= 1'b0;
                end
                default: begin
                    state      <= CLEAR_ON_RESET ? ST_CLEAR : ST_LOAD;
                    load_ready <= 1'b0;
                end
            endcase
        end
    end

    // Reset must never touch memory contents, so writes are gated by rst.
    always_comb begin
        imem_we    = 1'b0;
        imem_waddr = ld_addr;
        imem_wdata = bus.load_data;
        dmem_we    = 1'b0;
        dmem_waddr = bus.ALUOut;
        dmem_wdata = bus.rd2_Data;
        if (state == ST_CLEAR) begin
            imem_we    = !rst;
            imem_waddr = clr_cnt;
            imem_wdata = '0;
            dmem_we    = !rst;
            dmem_waddr = clr_cnt;
            dmem_wdata = '0;
        end else begin
            imem_we = !rst && xfer;
            dmem_we = !rst && (state == ST_RUN) && bus.MemWrite;
        end
    end

    mips_mem_array #(
        .W (IW),
        .AW(AW)
    ) u_imem (
        .clk  (clk),
        .we   (imem_we),
        .waddr(imem_waddr),
        .wdata(imem_wdata),
        .raddr(bus.pc),
        .rdata(bus.inst)
    );

    mips_mem_array #(
        .W (DW),
        .AW(AW)
    ) u_dmem (
        .clk  (clk),
        .we   (dmem_we),
        .waddr(dmem_waddr),
        .wdata(dmem_wdata),
        .raddr(bus.ALUOut),
        .rdata(bus.ReadData)
    );

    assign bus.load_ready = load_ready;
    assign bus.prog_len   = prog_len;
    assign bus.core_rst   = (state != ST_RUN);
endmodule

// File: tb/tb_mips_mem.sv
// Self-checking bench for mips_mem: boot sequence, loading, data port and reset corners.
module tb_mips_mem;
    logic clk;
    logic rst;
    logic rst1;

    mips_mem_if #(.IW(9), .AW(8), .DW(8)) bus0 ();
    mips_mem_if #(.IW(9), .AW(8), .DW(8)) bus1 ();

    mips_mem #(.IW(9), .AW(8), .DW(8), .CLEAR_ON_RESET(1'b1)) u_dut0 (
        .clk(clk),
        .rst(rst),
        .bus(bus0)
    );

    mips_mem #(.IW(9), .AW(8), .DW(8), .CLEAR_ON_RESET(1'b0)) u_dut1 (
        .clk(clk),
        .rst(rst1),
        .bus(bus1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    int n_chk;
    int n_pass;

    // Reference model: memory images plus loader bookkeeping.
    logic [8:0] m_imem [256];
    logic [7:0] m_dmem [256];
    int         m_ld;
    int         m_len;
    bit         m_run;

    typedef struct {
        logic [7:0] pc;
        logic [8:0] inst;
    } rd_vec_t;
    rd_vec_t t2 [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic m_clear();
        for (int a = 0; a < 256; a++) begin
            m_imem[a] = '0;
            m_dmem[a] = '0;
        end
        m_ld  = 0;
        m_len = 0;
        m_run = 0;
    endtask

    // Called at a negedge with rst just released; counts cycles until load_ready.
    task automatic wait_clear();
        int cnt;
        int bad;
        cnt = 0;
        bad = 0;
        while (bus0.load_ready !== 1'b1 && cnt < 400) begin
            @(negedge clk);
            cnt++;
            if (bus0.core_rst !== 1'b1) bad++;
        end
        chk("clear_cycles", cnt, 256);
        chk("core_rst_during_clear", bad, 0);
    endtask

    task automatic send_word(input logic [8:0] data, input logic last, input int gap);
        int  cnt;
        bit  done;
        logic r;
        bus0.load_valid = 1'b0;
        repeat (gap) @(negedge clk);
        bus0.load_valid = 1'b1;
        bus0.load_data  = data;
        bus0.load_last  = last;
        cnt  = 0;
        done = 0;
        while (!done && cnt < 20) begin
            r = bus0.load_ready;
            @(negedge clk);
            cnt++;
            if (r === 1'b1) done = 1;
        end
        bus0.load_valid = 1'b0;
        bus0.load_data  = 9'($urandom);
        bus0.load_last  = 1'($urandom);
        if (!done) begin
            chk("load_timeout", 0, 1);
        end else begin
            m_imem[m_ld] = data;
            m_ld++;
            m_len++;
            if (last || m_ld == 256) m_run = 1;
            chk("core_rst_after_xfer", bus0.core_rst, !m_run);
        end
    endtask

    task automatic scan_all(input string name);
        int bad;
        bad = 0;
        bus0.MemWrite = 1'b0;
        for (int a = 0; a < 256; a++) begin
            bus0.pc     = 8'(a);
            bus0.ALUOut = 8'(a);
            #1;
            if (bus0.inst !== m_imem[a] || bus0.ReadData !== m_dmem[a]) bad++;
        end
        chk(name, bad, 0);
        @(negedge clk);
    endtask

    task automatic rand_run(input int n);
        logic       mw;
        logic [7:0] addr;
        logic [7:0] data;
        logic [7:0] p;
        for (int i = 0; i < n; i++) begin
            mw   = 1'($urandom);
            addr = 8'($urandom);
            data = 8'($urandom);
            p    = 8'($urandom);
            bus0.MemWrite = mw;
            bus0.ALUOut   = addr;
            bus0.rd2_Data = data;
            bus0.pc       = p;
            #1;
            chk("rand_inst", bus0.inst, m_imem[p]);
            chk("rand_readdata", bus0.ReadData, m_dmem[addr]);
            if (mw) m_dmem[addr] = data;
            @(negedge clk);
        end
        bus0.MemWrite = 1'b0;
    endtask

    initial begin
        logic [8:0] old0;
        n_chk  = 0;
        n_pass = 0;
        t2[0] = '{pc: 8'd0, inst: 9'h1A5};
        t2[1] = '{pc: 8'd1, inst: 9'h003};
        t2[2] = '{pc: 8'd2, inst: 9'h0FF};
        t2[3] = '{pc: 8'd3, inst: 9'h000};

        rst  = 1'b1;
        rst1 = 1'b1;
        bus0.load_valid = 0; bus0.load_data = 0; bus0.load_last = 0; bus0.pc = 0;
        bus0.MemWrite = 0; bus0.ALUOut = 0; bus0.rd2_Data = 0;
        bus1.load_valid = 0; bus1.load_data = 0; bus1.load_last = 0; bus1.pc = 0;
        bus1.MemWrite = 0; bus1.ALUOut = 0; bus1.rd2_Data = 0;
        m_clear();

        // 1: reset and clear
        @(negedge clk);
        @(negedge clk);
        chk("rst_load_ready", bus0.load_ready, 0);
        chk("rst_core_rst", bus0.core_rst, 1);
        chk("rst_prog_len", bus0.prog_len, 0);
        rst = 1'b0;
        wait_clear();
        scan_all("clear_scan");

        // MemWrite during LOAD must not reach dmem
        bus0.MemWrite = 1'b1;
        bus0.ALUOut   = 8'h40;
        bus0.rd2_Data = 8'hAA;
        @(negedge clk);
        bus0.MemWrite = 1'b0;

        // 2: short program with gaps
        send_word(9'h1A5, 1'b0, 2);
        send_word(9'h003, 1'b0, 3);
        send_word(9'h0FF, 1'b1, 1);
        chk("t2_prog_len", bus0.prog_len, 3);
        chk("t2_load_ready", bus0.load_ready, 0);
        for (int i = 0; i < 4; i++) begin
            bus0.pc = t2[i].pc;
            #1;
            chk("t2_inst", bus0.inst, t2[i].inst);
        end
        @(negedge clk);

        // 4: write-then-read to one address in RUN
        bus0.ALUOut   = 8'h40;
        bus0.MemWrite = 1'b0;
        #1;
        chk("load_memwrite_ignored", bus0.ReadData, 8'h00);
        bus0.MemWrite = 1'b1;
        bus0.rd2_Data = 8'h5C;
        #1;
        chk("same_cycle_old", bus0.ReadData, 8'h00);
        @(negedge clk);
        bus0.MemWrite = 1'b0;
        m_dmem[8'h40] = 8'h5C;
        #1;
        chk("next_cycle_new", bus0.ReadData, 8'h5C);
        @(negedge clk);
        rand_run(150);

        // 5: reset mid-LOAD
        rst = 1'b1;
        @(negedge clk);
        chk("t5_rst_prog_len", bus0.prog_len, 0);
        chk("t5_rst_core_rst", bus0.core_rst, 1);
        chk("t5_rst_load_ready", bus0.load_ready, 0);
        rst = 1'b0;
        wait_clear();
        m_clear();
        bus0.MemWrite = 1'b1;
        bus0.ALUOut   = 8'h40;
        bus0.rd2_Data = 8'h77;
        send_word(9'h123, 1'b0, 0);
        send_word(9'h045, 1'b0, 1);
        bus0.MemWrite = 1'b0;
        chk("t5_prog_len_2", bus0.prog_len, 2);
        rst = 1'b1;
        @(negedge clk);
        chk("t5_prog_len_0", bus0.prog_len, 0);
        chk("t5_core_rst", bus0.core_rst, 1);
        rst = 1'b0;
        wait_clear();
        m_clear();
        scan_all("t5_clear_scan");

        // 3: full-depth stream without load_last
        for (int i = 0; i < 256; i++) begin
            send_word(9'($urandom), 1'b0, int'($urandom_range(0, 1)));
        end
        chk("t3_prog_len", bus0.prog_len, 256);
        chk("t3_load_ready", bus0.load_ready, 0);
        chk("t3_core_rst", bus0.core_rst, 0);
        old0 = m_imem[0];
        bus0.load_valid = 1'b1;
        bus0.load_data  = ~old0;
        bus0.load_last  = 1'b1;
        repeat (3) @(negedge clk);
        bus0.load_valid = 1'b0;
        bus0.pc = 8'd0;
        #1;
        chk("t3_extra_ignored", bus0.inst, old0);
        chk("t3_prog_len_hold", bus0.prog_len, 256);
        @(negedge clk);
        rand_run(150);
        scan_all("t3_final_scan");

        // 6: CLEAR_ON_RESET=0 instance
        rst1 = 1'b0;
        @(negedge clk);
        chk("t6_ready_first", bus1.load_ready, 1);
        chk("t6_core_rst", bus1.core_rst, 1);
        bus1.load_valid = 1'b1;
        bus1.load_data  = 9'h0AB;
        bus1.load_last  = 1'b0;
        @(negedge clk);
        bus1.load_data  = 9'h1C3;
        bus1.load_last  = 1'b1;
        @(negedge clk);
        bus1.load_valid = 1'b0;
        chk("t6_run_core_rst", bus1.core_rst, 0);
        chk("t6_prog_len", bus1.prog_len, 2);
        rst1 = 1'b1;
        @(negedge clk);
        rst1 = 1'b0;
        @(negedge clk);
        chk("t6_ready_again", bus1.load_ready, 1);
        chk("t6_prog_len_rst", bus1.prog_len, 0);
        chk("t6_core_rst_rst", bus1.core_rst, 1);
        bus1.pc = 8'd0;
        #1;
        chk("t6_keep0", bus1.inst, 9'h0AB);
        bus1.pc = 8'd1;
        #1;
        chk("t6_keep1", bus1.inst, 9'h1C3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
